// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: shared cache types and arbiter state encoding (rev 1.0)
`default_nettype none

package l2_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_I  = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: line-granular memory port; master issues requests, slave answers (rev 1.0)
`default_nettype none

interface l2_arbiter_if
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = $bits(lc3b_word),
  parameter int LINE_W = $bits(cache_line)
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

`default_nettype wire

// File: rtl/l2_arbiter.sv
// l2_arbiter: arbitrates I-cache and D-cache line requests onto the single L2 port (rev 1.0)
`default_nettype none

module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W     = $bits(lc3b_word),
  parameter int LINE_W     = $bits(cache_line),
  parameter int FIXED_PRIO = 0
)(
  input  wire logic      clk,
  input  wire logic      rst,
  l2_arbiter_if.slave    icache,
  l2_arbiter_if.slave    dcache,
  l2_arbiter_if.master   l2
);

  arb_state_t        r_state;
  grant_t            r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;

  logic w_req_i;
  logic w_req_d;
  logic w_pick_d;
  logic w_resp_i;
  logic w_resp_d;

  always_comb begin
    w_req_i = icache.mem_read;
    w_req_d = dcache.mem_read | dcache.mem_write;
    if (w_req_i && w_req_d)
      w_pick_d = (FIXED_PRIO != 0) || (r_last_grant == GRANT_I);
    else
      w_pick_d = w_req_d;
  end

  // L2 request fields come only from the captured registers, so they stay
  // stable for the whole transaction whatever the L1 side does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_D;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req_i || w_req_d) begin
            if (w_pick_d) begin
              r_addr       <= dcache.mem_address;
              r_wdata      <= dcache.mem_wdata;
              r_wr         <= dcache.mem_write;
              r_rd         <= ~dcache.mem_write;
              r_last_grant <= GRANT_D;
              r_state      <= ARB_BUSY_D;
            end else begin
              r_addr       <= icache.mem_address;
              r_wdata      <= '0;
              r_wr         <= 1'b0;
              r_rd         <= 1'b1;
              r_last_grant <= GRANT_I;
              r_state      <= ARB_BUSY_I;
            end
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (l2.mem_resp) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: r_state <= ARB_IDLE;
        default:     r_state <= ARB_IDLE;
      endcase
    end
  end

  assign l2.mem_read    = r_rd;
  assign l2.mem_write   = r_wr;
  assign l2.mem_address = r_addr;
  assign l2.mem_wdata   = r_wdata;

  // Response and data are routed combinationally to whichever side holds the grant.
  assign w_resp_i = (r_state == ARB_BUSY_I) && l2.mem_resp;
  assign w_resp_d = (r_state == ARB_BUSY_D) && l2.mem_resp;

  assign icache.mem_resp  = w_resp_i;
  assign icache.mem_rdata = w_resp_i ? l2.mem_rdata : '0;
  assign dcache.mem_resp  = w_resp_d;
  assign dcache.mem_rdata = w_resp_d ? l2.mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: vector table plus scoreboarded L2 model for l2_arbiter (rev 1.0)
`default_nettype none

module tb_l2_arbiter;
  import l2_arbiter_pkg::*;

  typedef struct {
    logic [15:0]  addr;
    bit           rd;
    bit           wr;
    logic [127:0] wdata;
  } req_t;

  typedef struct {
    bit           d;
    logic [15:0]  addr;
    bit           exp_rd;
    bit           exp_wr;
    logic [127:0] wdata;
    int           lat;
    logic [127:0] rdata;
    int           glat;
  } sb_t;

  typedef struct {
    bit           d;
    logic [15:0]  addr;
    bit           rd;
    bit           wr;
    logic [127:0] wdata;
    int           lat;
    logic [127:0] l2data;
    bit           exp_rd;
    bit           exp_wr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         i_rd, d_rd, d_wr, l2_resp;
  logic [15:0]  i_addr, d_addr;
  logic [127:0] d_wdata, l2_rdata;
  bit           sel;

  l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) ic0();
  l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) dc0();
  l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) l20();
  l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) ic1();
  l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) dc1();
  l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) l21();

  l2_arbiter #(.ADDR_W(16), .LINE_W(128), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst), .icache(ic0), .dcache(dc0), .l2(l20));
  l2_arbiter #(.ADDR_W(16), .LINE_W(128), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst), .icache(ic1), .dcache(dc1), .l2(l21));

  assign ic0.mem_read = i_rd;    assign ic1.mem_read = i_rd;
  assign ic0.mem_write = 1'b0;   assign ic1.mem_write = 1'b0;
  assign ic0.mem_address = i_addr; assign ic1.mem_address = i_addr;
  assign ic0.mem_wdata = '0;     assign ic1.mem_wdata = '0;
  assign dc0.mem_read = d_rd;    assign dc1.mem_read = d_rd;
  assign dc0.mem_write = d_wr;   assign dc1.mem_write = d_wr;
  assign dc0.mem_address = d_addr; assign dc1.mem_address = d_addr;
  assign dc0.mem_wdata = d_wdata; assign dc1.mem_wdata = d_wdata;
  assign l20.mem_resp = l2_resp; assign l21.mem_resp = l2_resp;
  assign l20.mem_rdata = l2_rdata; assign l21.mem_rdata = l2_rdata;

  logic         w_i_resp, w_d_resp, w_l2_rd, w_l2_wr;
  logic [127:0] w_i_rdata, w_d_rdata, w_l2_wdata;
  logic [15:0]  w_l2_addr;
  assign w_i_resp   = sel ? ic1.mem_resp    : ic0.mem_resp;
  assign w_d_resp   = sel ? dc1.mem_resp    : dc0.mem_resp;
  assign w_i_rdata  = sel ? ic1.mem_rdata   : ic0.mem_rdata;
  assign w_d_rdata  = sel ? dc1.mem_rdata   : dc0.mem_rdata;
  assign w_l2_rd    = sel ? l21.mem_read    : l20.mem_read;
  assign w_l2_wr    = sel ? l21.mem_write   : l20.mem_write;
  assign w_l2_addr  = sel ? l21.mem_address : l20.mem_address;
  assign w_l2_wdata = sel ? l21.mem_wdata   : l20.mem_wdata;

  req_t iq[$];
  req_t dq[$];
  sb_t  exp_q[$];
  sb_t  cur;
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   i_since = 0;
  int   d_since = 0;
  int   l2_cnt = 0;
  bit   l2_busy, i_prev, d_prev, saw_i, saw_d;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input bit d, input logic [15:0] addr, input bit rd, input bit wr,
                     input logic [127:0] wdata, input int lat, input logic [127:0] rdata,
                     input int glat, input bit exp_rd, input bit exp_wr);
    req_t r;
    sb_t  s;
    r = '{addr, rd, wr, wdata};
    s = '{d, addr, exp_rd, exp_wr, wdata, lat, rdata, glat};
    if (d) dq.push_back(r);
    else   iq.push_back(r);
    exp_q.push_back(s);
  endtask

  task automatic drive_l1();
    i_rd   = (iq.size() > 0);
    i_addr = i_rd ? iq[0].addr : 16'h0;
    if (i_rd && !i_prev) i_since = cyc;
    i_prev = i_rd;
    if (dq.size() > 0) begin
      d_rd = dq[0].rd; d_wr = dq[0].wr; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
      if (!d_prev) d_since = cyc;
      d_prev = 1'b1;
    end else begin
      d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
      d_prev = 1'b0;
    end
  endtask

  // One clock: L2 model and L1 drivers update after the falling edge, outputs sampled 1ns later.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (l2_resp) begin
      l2_resp = 1'b0;
      l2_rdata = '0;
      chk("l2_req_drop", {w_l2_rd, w_l2_wr}, 0);
    end else if (w_l2_rd || w_l2_wr) begin
      if (!l2_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_l2_req", {w_l2_rd, w_l2_wr}, 0);
          cur = '{0, w_l2_addr, 1'b1, 1'b0, '0, 1, '0, 0};
        end else begin
          cur = exp_q.pop_front();
        end
        l2_busy = 1'b1;
        l2_cnt = 0;
        chk("l2_addr", w_l2_addr, cur.addr);
        chk("l2_read", w_l2_rd, cur.exp_rd);
        chk("l2_write", w_l2_wr, cur.exp_wr);
        if (cur.exp_wr) chk("l2_wdata", w_l2_wdata, cur.wdata);
        if (cur.glat != 0) chk("grant_lat", cyc - (cur.d ? d_since : i_since), cur.glat);
      end else begin
        chk("l2_addr_hold", w_l2_addr, cur.addr);
      end
      l2_cnt++;
      if (l2_cnt >= cur.lat) begin
        l2_resp = 1'b1;
        l2_rdata = cur.rdata;
        l2_busy = 1'b0;
      end
    end
    drive_l1();
    #1;
    saw_i = w_i_resp;
    saw_d = w_d_resp;
    if (l2_resp) begin
      chk("i_resp", w_i_resp, !cur.d);
      chk("d_resp", w_d_resp, cur.d);
      chk("i_rdata", w_i_rdata, cur.d ? 128'd0 : cur.rdata);
      chk("d_rdata", w_d_rdata, cur.d ? cur.rdata : 128'd0);
      if (cur.d && dq.size() > 0) void'(dq.pop_front());
      else if (!cur.d && iq.size() > 0) void'(iq.pop_front());
    end else begin
      chk("idle_resp", {w_i_resp, w_d_resp}, 0);
      chk("idle_rdata", w_i_rdata | w_d_rdata, 0);
    end
  endtask

  task automatic wait_idle(input int max);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      if (iq.size() == 0 && dq.size() == 0 && exp_q.size() == 0 && !l2_busy && !l2_resp) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", done, 1);
    step();
  endtask

  task automatic wait_busy(input int max);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      if (l2_busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("busy_timeout", done, 1);
  endtask

  task automatic clear_model();
    iq.delete(); dq.delete(); exp_q.delete();
    l2_busy = 1'b0; l2_resp = 1'b0; l2_rdata = '0;
    i_prev = 1'b0; d_prev = 1'b0;
    drive_l1();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_l2_req", {w_l2_rd, w_l2_wr}, 0);
    chk("rst_l2_addr", w_l2_addr, 0);
    chk("rst_l2_wdata", w_l2_wdata, 0);
    chk("rst_resp", {w_i_resp, w_d_resp}, 0);
  endtask

  initial begin
    bit got;
    sel = 1'b0;
    clear_model();
    vecs[0] = '{0, 16'h1230, 1, 0, '0, 5, {16{8'hA5}}, 1, 0};
    vecs[1] = '{1, 16'h0800, 1, 0, '0, 1, {8{16'h0123}}, 1, 0};
    vecs[2] = '{1, 16'h2200, 0, 1, {8{16'hDEAD}}, 2, {4{32'h0F0F_0F0F}}, 0, 1};
    vecs[3] = '{1, 16'h3300, 1, 1, {8{16'hBEEF}}, 3, '0, 0, 1};
    vecs[4] = '{0, 16'hFFFE, 1, 0, '0, 1, {128{1'b1}}, 1, 0};

    do_reset();

    // Simultaneous I read and D write straight out of reset: I first.
    add(0, 16'h0100, 1, 0, '0, 3, {8{16'h0100}}, 1, 1, 0);
    add(1, 16'h2200, 0, 1, {8{16'hDEAD}}, 3, {8{16'h2200}}, 0, 0, 1);
    wait_idle(60);

    // Continuous requests on both sides must alternate.
    for (int k = 0; k < 3; k++) begin
      add(0, 16'h1000 + 16'(k * 16), 1, 0, '0, 2, {8{16'h1000 + 16'(k)}}, 0, 1, 0);
      add(1, 16'h2000 + 16'(k * 16), 1, 0, '0, 2, {8{16'h2000 + 16'(k)}}, 0, 1, 0);
    end
    wait_idle(200);

    for (int v = 0; v < 5; v++) begin
      add(vecs[v].d, vecs[v].addr, vecs[v].rd, vecs[v].wr, vecs[v].wdata, vecs[v].lat,
          vecs[v].l2data, 1, vecs[v].exp_rd, vecs[v].exp_wr);
      wait_idle(60);
    end

    // D address changes while busy; L2 must keep the captured one.
    add(1, 16'h4000, 1, 0, '0, 6, {8{16'h4000}}, 1, 1, 0);
    wait_busy(20);
    dq[0].addr = 16'h5000;
    wait_idle(60);

    // I drops its request mid-transaction; a new one is granted after RELEASE+IDLE.
    add(0, 16'h0440, 1, 0, '0, 4, {8{16'h0440}}, 1, 1, 0);
    wait_busy(20);
    void'(iq.pop_front());
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (saw_i) begin
        got = 1'b1;
        break;
      end
    end
    chk("drop_resp_seen", got, 1);
    add(0, 16'h0550, 1, 0, '0, 2, {8{16'h0550}}, 2, 1, 0);
    wait_idle(60);

    // Asynchronous reset while BUSY_D.
    add(1, 16'h3000, 1, 0, '0, 30, {8{16'h3000}}, 1, 1, 0);
    wait_busy(20);
    step();
    chk("busy_l2_read", w_l2_rd, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_l2_read", w_l2_rd, 0);
    chk("async_rst_l2_addr", w_l2_addr, 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // D-priority instance: D wins every tie until it idles.
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++)
      add(1, 16'h6000 + 16'(k * 16), 1, 0, '0, 2, {8{16'h6000 + 16'(k)}}, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      add(0, 16'h7000 + 16'(k * 16), 1, 0, '0, 2, {8{16'h7000 + 16'(k)}}, 0, 1, 0);
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

`default_nettype wire
